// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: debounces the four board buttons and sequences the
// flowing-light shifter (load/step strobes, direction, step rate).

// One button front end: 2-FF synchronizer, stability debounce and a
// one-cycle press pulse on the rising edge of the debounced level.
module led_flow_btn #(
  parameter int unsigned DB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam logic [31:0] DB_LAST = 32'(DB_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [31:0] db_cnt;

  // Bring the raw asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Level follows the synchronized input only after DB_CYCLES stable cycles; a release flips it silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync2;
        db_cnt <= '0;
        press  <= sync2;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end
endmodule

// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start; no steps, counter idle
// ST_RUN   | tick counter runs, step pulses every P cycles
// ST_PAUSE | counter frozen at its held value, no steps
module led_flow_ctrl #(
  parameter int unsigned TICK_BASE = 100_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_dir,
  input  logic       btn_speed,
  output logic       load,
  output logic       step,
  output logic       dir,
  output logic [1:0] speed,
  output logic [1:0] state
);
  localparam logic [31:0] TB32 = 32'(TICK_BASE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic [31:0] tick_cnt;
  logic [31:0] tick_nxt;
  logic [31:0] period_m1;
  logic [31:0] period_nxt;
  logic        load_nxt;
  logic        step_nxt;
  logic        dir_nxt;
  logic [1:0]  speed_nxt;
  logic        wrap;
  logic        ev_start;
  logic        ev_pause;
  logic        ev_dir;
  logic        ev_speed;

  led_flow_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .press(ev_start));
  led_flow_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_pause (.clk(clk), .rst_n(rst_n), .btn(btn_pause), .press(ev_pause));
  led_flow_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_dir   (.clk(clk), .rst_n(rst_n), .btn(btn_dir),   .press(ev_dir));
  led_flow_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_speed (.clk(clk), .rst_n(rst_n), .btn(btn_speed), .press(ev_speed));

  assign state = state_q;

  // State, tick counter, registered P-1 and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tick_cnt  <= '0;
      period_m1 <= TB32 - 32'd1;
      load      <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      speed     <= 2'b00;
    end else begin
      state_q   <= state_nxt;
      tick_cnt  <= tick_nxt;
      period_m1 <= period_nxt;
      load      <= load_nxt;
      step      <= step_nxt;
      dir       <= dir_nxt;
      speed     <= speed_nxt;
    end
  end

  // Next-state: start beats pause and cancels a same-cycle wrap; a speed press always restarts the period.
  always_comb begin
    state_nxt = state_q;
    tick_nxt  = tick_cnt;
    load_nxt  = 1'b0;
    step_nxt  = 1'b0;
    dir_nxt   = dir ^ ev_dir;
    speed_nxt = speed + {1'b0, ev_speed};
    wrap      = (tick_cnt == period_m1);
    case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          load_nxt  = 1'b1;
          tick_nxt  = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ev_start) begin
          load_nxt = 1'b1;
          tick_nxt = '0;
        end else if (ev_pause) begin
          state_nxt = ST_PAUSE;
        end else begin
          tick_nxt = wrap ? '0 : tick_cnt + 32'd1;
          step_nxt = wrap;
        end
      end
      ST_PAUSE: begin
        if (ev_start) begin
          load_nxt  = 1'b1;
          tick_nxt  = '0;
          state_nxt = ST_RUN;
        end else if (ev_pause) begin
          // The resume cycle already counts, so the remaining P-1-k cycles run out on time.
          state_nxt = ST_RUN;
          tick_nxt  = wrap ? '0 : tick_cnt + 32'd1;
          step_nxt  = wrap;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (ev_speed) tick_nxt = '0;
    period_nxt = (TB32 >> speed_nxt) - 32'd1;
  end
endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with TICK_BASE=16, DB_CYCLES=4.
module tb_led_flow_ctrl;
  logic       clk;
  logic       rst_n;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_dir;
  logic       btn_speed;
  logic       load;
  logic       step;
  logic       dir;
  logic [1:0] speed;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_q[$];
  int step_q[$];
  logic both_seen = 1'b0;

  led_flow_ctrl #(.TICK_BASE(16), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_dir(btn_dir), .btn_speed(btn_speed),
    .load(load), .step(step), .dir(dir), .speed(speed), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every load/step pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load) load_q.push_back(cyc);
      if (step) step_q.push_back(cyc);
      if (load && step) both_seen = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required below 10000", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mask order: start, pause, dir, speed
  task automatic press(input logic [3:0] m, input int hold);
    {btn_start, btn_pause, btn_dir, btn_speed} = m;
    cycles(hold);
    {btn_start, btn_pause, btn_dir, btn_speed} = 4'b0000;
  endtask

  task automatic wait_one_step(output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (step) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_steps(input int n);
    for (int i = 0; i < 200; i++) begin
      if (step_q.size() >= n) break;
      cycles(1);
    end
  endtask

  function automatic int step_at(input int i);
    return (i < step_q.size()) ? step_q[i] : -1;
  endfunction

  function automatic int step_last();
    return (step_q.size() > 0) ? step_q[$] : -1;
  endfunction

  function automatic int load_last();
    return (load_q.size() > 0) ? load_q[$] : -1;
  endfunction

  function automatic int first_step_after(input int c);
    foreach (step_q[i]) if (step_q[i] > c) return step_q[i];
    return -1;
  endfunction

  initial begin
    int r;
    int l0;
    int s;
    int at;
    int n;
    int nl;

    // 1. reset with button noise
    rst_n = 1'b0;
    {btn_start, btn_pause, btn_dir, btn_speed} = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      {btn_start, btn_pause, btn_dir, btn_speed} = 4'($urandom_range(0, 15));
    end
    #2;
    chk("reset_outputs", 32'({load, step, dir, speed, state}), 32'd0);
    {btn_start, btn_pause, btn_dir, btn_speed} = 4'b0000;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("post_reset_loads", load_q.size(), 0);
    chk("post_reset_steps", step_q.size(), 0);
    chk("post_reset_state", 32'(state), 32'd0);

    // 2. debounce: short glitch ignored, long press gives one load 7 cycles after rise
    press(4'b1000, 3);
    cycles(15);
    chk("glitch_no_load", load_q.size(), 0);
    chk("glitch_state", 32'(state), 32'd0);
    r = cyc;
    press(4'b1000, 10);
    cycles(2);
    chk("start_load_count", load_q.size(), 1);
    chk("start_load_latency", load_last() - r, 7);
    chk("start_state_run", 32'(state), 32'd1);
    l0 = r + 7;

    // 3. run rate at speed 0, then speed 1, then wrap back to 0
    wait_steps(3);
    chk("first_step", step_at(0), l0 + 16);
    chk("step_gap0_a", step_at(1) - step_at(0), 16);
    chk("step_gap0_b", step_at(2) - step_at(1), 16);
    s = cyc;
    press(4'b0001, 8);
    chk("speed_1", 32'(speed), 32'd1);
    step_q.delete();
    wait_steps(2);
    chk("speed1_first_step", step_at(0), s + 15);
    chk("speed1_gap", step_at(1) - step_at(0), 8);
    cycles(4);
    press(4'b0001, 8);
    chk("speed_2", 32'(speed), 32'd2);
    cycles(8);
    press(4'b0001, 8);
    chk("speed_3", 32'(speed), 32'd3);
    cycles(8);
    press(4'b0001, 8);
    chk("speed_wrap_0", 32'(speed), 32'd0);
    cycles(8);

    // 4. pause at k=4, stay quiet, resume: next step 12 cycles after the event
    step_q.delete();
    wait_one_step(at);
    cycles(14);
    press(4'b0100, 8);
    chk("pause_state", 32'(state), 32'd2);
    chk("step_before_pause", step_last(), at + 16);
    n = step_q.size();
    cycles(100);
    chk("paused_no_steps", step_q.size(), n);
    chk("paused_state_hold", 32'(state), 32'd2);
    r = cyc;
    press(4'b0100, 8);
    chk("resume_state", 32'(state), 32'd1);
    cycles(22);
    chk("resume_step", first_step_after(r), r + 18);

    // 5. start+pause together in RUN, then start from PAUSE
    nl = load_q.size();
    r = cyc;
    press(4'b1100, 8);
    chk("restart_one_load", load_q.size(), nl + 1);
    chk("restart_load_cycle", load_last(), r + 7);
    chk("restart_state", 32'(state), 32'd1);
    cycles(25);
    chk("restart_first_step", first_step_after(r + 7), r + 23);
    press(4'b0100, 8);
    chk("pause_again", 32'(state), 32'd2);
    cycles(8);
    r = cyc;
    press(4'b1000, 8);
    chk("start_from_pause_load", load_last(), r + 7);
    chk("start_from_pause_state", 32'(state), 32'd1);
    cycles(8);

    // 6. direction toggle, then reset mid-period
    press(4'b0010, 8);
    chk("dir_toggled", 32'(dir), 32'd1);
    wait_one_step(at);
    chk("step_seen_after_dir", 32'(at >= 0), 32'd1);
    chk("dir_at_step", 32'(dir), 32'd1);
    cycles(5);
    rst_n = 1'b0;
    #2;
    chk("midrun_reset_outputs", 32'({load, step, dir, speed, state}), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    step_q.delete();
    load_q.delete();
    cycles(40);
    chk("after_reset_no_steps", step_q.size(), 0);
    chk("after_reset_no_loads", load_q.size(), 0);
    chk("after_reset_idle", 32'(state), 32'd0);
    chk("load_step_exclusive", 32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
